// File: rtl/wash_run.sv
// Wash execution stage: BCD price deduction, timed wash/rinse/spin
// sequence on a 1 s tick, with pause/resume and funds error.
module wash_run #(
  parameter int TICK_CYC   = 100_000_000,
  parameter int DONE_TICKS = 3,
  parameter int ERR_TICKS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_on,
  input  logic        pause,
  input  logic [11:0] bal_in,
  input  logic [1:0]  mode,
  output logic [11:0] bal_out,
  output logic [11:0] rem_bcd,
  output logic [2:0]  phase,
  output logic        busy,
  output logic        paused,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WASH  = 3'd1,
    RINSE = 3'd2,
    SPIN  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICK_CYC - 1);

  function automatic logic [11:0] price_of(input logic [1:0] m);
    unique case (m)
      2'd0:    return 12'h010;
      2'd1:    return 12'h015;
      2'd2:    return 12'h020;
      default: return 12'h025;
    endcase
  endfunction

  function automatic logic [11:0] total_of(input logic [1:0] m);
    unique case (m)
      2'd0:    return 12'h006;
      2'd1:    return 12'h012;
      2'd2:    return 12'h018;
      default: return 12'h005;
    endcase
  endfunction

  function automatic logic [3:0] dur_of(input logic [1:0] m,
                                        input logic [2:0] s);
    logic [11:0] row;
    unique case (m)
      2'd0:    row = 12'h321;
      2'd1:    row = 12'h642;
      2'd2:    row = 12'h963;
      default: row = 12'h005;
    endcase
    unique case (s)
      3'd1:    return row[11:8];
      3'd2:    return row[7:4];
      3'd3:    return row[3:0];
      default: return 4'd0;
    endcase
  endfunction

  // First phase at or after s whose duration is nonzero; DONE if none.
  function automatic state_t first_from(input logic [1:0] m,
                                        input logic [2:0] s);
    if (s <= 3'd1 && dur_of(m, 3'd1) != 4'd0) return WASH;
    if (s <= 3'd2 && dur_of(m, 3'd2) != 4'd0) return RINSE;
    if (s <= 3'd3 && dur_of(m, 3'd3) != 4'd0) return SPIN;
    return DONE;
  endfunction

  function automatic logic [11:0] bcd_sub(input logic [11:0] a,
                                          input logic [11:0] b);
    logic [11:0] r;
    logic [4:0]  d;
    logic        bw;
    r  = '0;
    bw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, bw};
      if (d[4]) begin
        r[4*i +: 4] = d[3:0] + 4'd10;
        bw = 1'b1;
      end else begin
        r[4*i +: 4] = d[3:0];
        bw = 1'b0;
      end
    end
    return r;
  endfunction

  state_t        state, state_n, nxt;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0]    cnt, cnt_n;
  logic [11:0]   rem, rem_n;
  logic [11:0]   bal, bal_n;
  logic [1:0]    mode_q, mode_n;
  logic          pz, pz_n;
  logic          run, pevt, wrap, tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tcnt   <= '0;
      cnt    <= '0;
      rem    <= '0;
      bal    <= '0;
      mode_q <= '0;
      pz     <= 1'b0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      cnt    <= cnt_n;
      rem    <= rem_n;
      bal    <= bal_n;
      mode_q <= mode_n;
      pz     <= pz_n;
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    cnt_n   = cnt;
    rem_n   = rem;
    bal_n   = bal;
    mode_n  = mode_q;
    pz_n    = pz;
    nxt     = IDLE;
    run  = (state == WASH) || (state == RINSE) || (state == SPIN);
    pevt = pause && run;
    wrap = (tcnt == TLAST);
    // A pause pulse on the wrap cycle wins over the tick.
    tick = wrap && !pz && !pevt;
    if (!(pz || pevt)) tcnt_n = wrap ? '0 : tcnt + 1'b1;
    if (pevt) pz_n = !pz;
    unique case (state)
      IDLE: begin
        tcnt_n = '0;
        if (start && is_on) begin
          mode_n = mode;
          if (bal_in < price_of(mode)) begin
            state_n = ERR;
            bal_n   = bal_in;
            rem_n   = '0;
            cnt_n   = 8'(ERR_TICKS);
          end else begin
            nxt     = first_from(mode, 3'd1);
            state_n = nxt;
            bal_n   = bcd_sub(bal_in, price_of(mode));
            rem_n   = total_of(mode);
            cnt_n   = {4'd0, dur_of(mode, nxt)};
          end
        end
      end
      WASH, RINSE, SPIN: begin
        if (tick) begin
          rem_n = bcd_sub(rem, 12'h001);
          if (cnt <= 8'd1) begin
            nxt     = first_from(mode_q, 3'(state) + 3'd1);
            state_n = nxt;
            cnt_n   = (nxt == DONE) ? 8'(DONE_TICKS)
                                    : {4'd0, dur_of(mode_q, nxt)};
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      DONE, ERR: begin
        if (tick) begin
          if (cnt <= 8'd1) state_n = IDLE;
          else cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) tcnt_n = '0;
    if (!(state_n == WASH || state_n == RINSE || state_n == SPIN))
      pz_n = 1'b0;
  end

  assign bal_out = bal;
  assign rem_bcd = rem;
  assign phase   = 3'(state);
  assign busy    = run;
  assign paused  = pz;
  assign done    = (state == DONE);
  assign err     = (state == ERR);

endmodule

// File: tb/tb_wash_run.sv
// Scoreboard bench for wash_run: a timing model queues expected
// output changes, a negedge monitor pops and compares them.
module tb_wash_run;

  localparam int T  = 4;
  localparam int DT = 3;
  localparam int ET = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_on = 1'b0;
  logic        pause = 1'b0;
  logic [11:0] bal_in = '0;
  logic [1:0]  mode = '0;
  logic [11:0] bal_out, rem_bcd;
  logic [2:0]  phase;
  logic        busy, paused, done, err;

  wash_run #(.TICK_CYC(T), .DONE_TICKS(DT), .ERR_TICKS(ET)) dut (
    .clk(clk), .rst(rst), .start(start), .is_on(is_on),
    .pause(pause), .bal_in(bal_in), .mode(mode),
    .bal_out(bal_out), .rem_bcd(rem_bcd), .phase(phase),
    .busy(busy), .paused(paused), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] v;
    int          t;
  } ev_t;

  ev_t         q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          base = 0;
  logic        mon_en = 1'b0;
  logic [30:0] last = '0;

  int price[4] = '{10, 15, 20, 25};
  int dw[4]    = '{3, 6, 9, 0};
  int dr[4]    = '{2, 4, 6, 0};
  int ds[4]    = '{1, 2, 3, 5};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [30:0] snap();
    return {busy, paused, done, err, phase, rem_bcd, bal_out};
  endfunction

  function automatic logic [30:0] mk(input bit b, input bit p,
    input bit d, input bit e, input int ph, input logic [11:0] r,
    input logic [11:0] bo);
    return {b, p, d, e, 3'(ph), r, bo};
  endfunction

  function automatic int to_int(input logic [11:0] x);
    return 100 * int'(x[11:8]) + 10 * int'(x[7:4]) + int'(x[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic push(input logic [30:0] v, input int t);
    ev_t e;
    e.v = v;
    e.t = t;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [30:0] s;
    ev_t e;
    if (mon_en) begin
      s = snap();
      if (s !== last) begin
        if (q.size() == 0) begin
          chk("unexpected_change", 32'(s), 32'(last));
        end else begin
          e = q.pop_front();
          chk("event_value", 32'(s), 32'(e.v));
          chk("event_cycle", 32'(cyc - base), 32'(e.t));
        end
        last = s;
      end
    end
  end

  // Expected output changes, cycle offsets relative to the accept edge.
  task automatic model(input int m, input logic [11:0] bal,
                       input int p, input int r);
    int b, tot, sh, pst, t, ph, cph;
    logic [11:0] nb, crem;
    b = to_int(bal);
    if (b < price[m]) begin
      push(mk(0, 0, 0, 1, 5, 12'h0, bal), 0);
      push(mk(0, 0, 0, 0, 0, 12'h0, bal), ET * T);
      return;
    end
    nb   = to_bcd(b - price[m]);
    tot  = dw[m] + dr[m] + ds[m];
    sh   = (p > 0) ? r - p + 1 : 0;
    cph  = (dw[m] > 0) ? 1 : (dr[m] > 0) ? 2 : 3;
    crem = to_bcd(tot);
    pst  = 0;
    push(mk(1, 0, 0, 0, cph, crem, nb), 0);
    for (int n = 1; n <= tot + DT; n++) begin
      t = n * T;
      if (p > 0 && t >= p) t += sh;
      if (p > 0 && pst == 0 && p < t) begin
        push(mk(1, 1, 0, 0, cph, crem, nb), p);
        pst = 1;
      end
      if (pst == 1 && r < t) begin
        push(mk(1, 0, 0, 0, cph, crem, nb), r);
        pst = 2;
      end
      if (n <= tot) begin
        ph = (n < dw[m]) ? 1 : (n < dw[m] + dr[m]) ? 2 :
             (n < tot) ? 3 : 4;
        cph  = ph;
        crem = to_bcd(tot - n);
        push(mk(ph < 4, 0, ph == 4, 0, ph, crem, nb), t);
      end else if (n == tot + DT) begin
        push(mk(0, 0, 0, 0, 0, 12'h0, nb), t);
      end
    end
  endtask

  task automatic run(input int m, input logic [11:0] bal,
    input int p, input int r, input int s, input bit pz,
    input int rst_at);
    @(negedge clk);
    base = cyc + 1;
    model(m, bal, pz ? 0 : p, r);
    mode   = 2'(m);
    bal_in = bal;
    is_on  = 1'b1;
    start  = 1'b1;
    pause  = pz;
    @(negedge clk);
    start  = 1'b0;
    pause  = 1'b0;
    mode   = 2'(3 - m);
    bal_in = 12'h999;
    for (int i = 0; i < 400 && q.size() > 0; i++) begin
      if (rst_at > 0 && cyc - base == rst_at) begin
        mon_en = 1'b0;
        #1 rst = 1'b0;
        #1 chk("async_reset", 32'(snap()), 32'h0);
        q.delete();
        rst    = 1'b1;
        last   = '0;
        mon_en = 1'b1;
        break;
      end
      if (p > 0 && cyc + 1 - base == p) pause = 1'b1;
      if (r > 0 && cyc + 1 - base == r) pause = 1'b1;
      if (s > 0 && cyc + 1 - base == s) start = 1'b1;
      @(negedge clk);
      pause = 1'b0;
      start = 1'b0;
    end
    chk("queue_drained", 32'(q.size()), 32'h0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_snapshot", 32'(snap()), 32'h0);
    chk("reset_phase", 32'(phase), 32'h0);
    rst    = 1'b1;
    mon_en = 1'b1;
    run(0, 12'h123, 0, 0, 0, 0, 0);
    run(3, 12'h025, 0, 0, 0, 0, 0);
    run(2, 12'h019, 0, 0, 0, 0, 0);
    run(1, 12'h100, 10, 30, 0, 0, 0);
    run(2, 12'h050, 0, 0, 20, 0, 40);
    @(negedge clk);
    is_on  = 1'b0;
    mode   = 2'd0;
    bal_in = 12'h123;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("is_on_low_ignored", 32'({phase, busy, err, bal_out}), 32'h0);
    run(0, 12'h010, 0, 0, 0, 1, 0);
    run(1, 12'h200, 0, 0, 0, 0, 0);
    run(0, 12'h050, 4, 10, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_run.md
# wash_run

Wash-execution stage directly downstream of the pre-stage panel (balance entry, mode select, confirm). On an accepted start it checks the latched balance against the mode price, deducts the price in BCD, and runs the mode's wash → rinse → spin sequence on a 1-second tick. It produces the remaining-time digits and phase code for the display scanner, plus the post-deduction balance. Supports pause/resume and signals insufficient funds.

## Interface
- `TICK_CYC`, default 100_000_000: clock cycles per 1-second tick (override small in simulation).
- `DONE_TICKS`, default 3: ticks the DONE indication is held.
- `ERR_TICKS`, default 2: ticks the ERR indication is held.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse (debounced confirm press); honoured only when `is_on`=1 and state is IDLE.
- `is_on` in 1: pre-stage permission to start.
- `pause` in 1: one-cycle pulse; toggles pause while running.
- `bal_in` in 12: 3-digit BCD balance, [3:0] units, [7:4] tens, [11:8] hundreds.
- `mode` in 2: wash mode, 0–3.
- `bal_out` out 12: BCD balance after deduction.
- `rem_bcd` out 12: 3-digit BCD total seconds remaining.
- `phase` out 3: 0 idle, 1 wash, 2 rinse, 3 spin, 4 done, 5 error.
- `busy` out 1: high in WASH/RINSE/SPIN, including while paused.
- `paused` out 1: pause active.
- `done` out 1: high throughout DONE.
- `err` out 1: high throughout ERR.

## Operation
- States: IDLE, WASH, RINSE, SPIN, DONE, ERR.
- Mode table, as price (BCD) and wash/rinse/spin seconds:
  - mode 0: price 10; 3/2/1
  - mode 1: price 15; 6/4/2
  - mode 2: price 20; 9/6/3
  - mode 3: price 25; 0/0/5
- `start` handling:
  - On `start` in IDLE with `is_on`=1, latch `mode` and `bal_in`.
  - If `bal_in` < price: go to ERR; `bal_out` = `bal_in`.
  - Otherwise `bal_out` = `bal_in` − price. Subtraction is 3-digit BCD, digit-wise with borrow; the result is never negative.
  - `start` is ignored when `is_on`=0 or the state is not IDLE.
- Phase entry: `rem_bcd` loads the mode's total seconds (6/12/18/5) in BCD. The first phase with nonzero duration is entered, so mode 3 goes straight to SPIN.
- Tick counter: counts 0..`TICK_CYC`−1. It clears on start acceptance and on every state change, and is frozen while paused.
- On each tick in a running phase:
  - The phase counter and `rem_bcd` both decrement. BCD decrement borrows across digits; digit 0 wraps to 9 with a borrow.
  - When the phase counter reaches 0, move to the next nonzero phase, or to DONE after SPIN.
- DONE holds for `DONE_TICKS` ticks, then goes to IDLE. ERR holds for `ERR_TICKS` ticks, then goes to IDLE.
- `pause` pulse in WASH/RINSE/SPIN toggles `paused`. It is ignored in other states, and `paused` clears on leaving the running phases.
- `bal_out` holds its value in IDLE/DONE/ERR until the next accepted start.

## Timing
- Reset values: state IDLE; `bal_out`=0; `rem_bcd`=0; `phase`=0; `busy`, `paused`, `done`, `err` all 0; tick counter 0.
- `start` is sampled on the rising `clk` edge. The edge after the start cycle shows `busy`=1 (or `err`=1), the new `phase`, the loaded `rem_bcd` and the updated `bal_out`.
- The first decrement occurs `TICK_CYC` cycles after start acceptance.
- The phase change and the final decrement occur on the same edge. `rem_bcd`=0 and `phase`=4 appear together.
- A `pause` pulse on the same cycle as a tick wrap takes effect first: no decrement occurs.
- `start` and `pause` arriving together in IDLE: start is processed and pause is ignored.
- Asserting `rst` at any time immediately forces all reset values. Any deducted balance is not restored.

## Test plan
- Mode 0, `bal_in`=0x123, `TICK_CYC`=4, start → `bal_out`=0x113, `rem_bcd` goes 6,5,…,0; `phase` goes 1×3 ticks, 2×2, 3×1, then 4 for 3 ticks, then 0.
- Mode 3, `bal_in`=0x025, start → `bal_out`=0x000, `phase`=3 directly, `rem_bcd`=5, DONE after 5 ticks.
- Mode 2, `bal_in`=0x019, start → `phase`=5, `err`=1 for 2 ticks, `bal_out`=0x019, then IDLE.
- Mode 1, `bal_in`=0x100, start; at `rem_bcd`=10, pause for 20 cycles, then resume → `bal_out`=0x085. The BCD borrow takes `rem_bcd` from 0x010 to 0x009, and the count is frozen during the pause.
- Running mode 2: `start` pulses are ignored; `rst` mid-RINSE gives all outputs 0 asynchronously; `start` with `is_on`=0 gives no response.
- Boundary: `bal_in`=0x010 with mode 0 → `bal_out`=0x000 accepted; `bal_in`=0x200 with mode 1 → `bal_out`=0x185.
